tqvp_hx2003_pulse_receiver: RTL



---
 rtl/pulse_receiver_pkg.sv | 26 ++
 rtl/pulse_receiver_word_fifo.sv | 55 +++++
 rtl/tqvp_hx2003_pulse_receiver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pulse_receiver_pkg.sv
// Shared types and constants for the pulse receiver: symbol encoding, capture
// FSM states and the duration classifier.
package pulse_receiver_pkg;

   localparam int unsigned SYM_PER_WORD       = 16;
   localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

   typedef logic [1:0] symbol_t;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   // Bit 1 carries the segment level, bit 0 flags a long segment.
   function automatic symbol_t classify(input logic       level,
                                        input logic [7:0] dur,
                                        input logic [7:0] thr_low,
                                        input logic [7:0] thr_high);
      logic [7:0] thr;
      thr = level ? thr_high : thr_low;
      return {level, dur >= thr};
   endfunction

endpackage

// File: rtl/pulse_receiver_word_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise it is dropped and flagged.
module pulse_receiver_word_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LEVEL);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && !push_ok;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// Edge-timestamping pulse receiver: classifies high/low segments into 2-bit
// symbols, packs 16 per word into a FIFO. Option: PULSE_RECEIVER_GLITCH_FILTER_EN.
module tqvp_hx2003_pulse_receiver
   import pulse_receiver_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sig_in,
   input  logic                          en,
   input  logic                          invert,
   input  logic [3:0]                    prescaler,
   input  logic [7:0]                    thr_low,
   input  logic [7:0]                    thr_high,
   input  logic [7:0]                    idle_timeout,
   input  logic                          rd_en,
   output logic [31:0]                   rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [4:0]                    last_len,
   output logic                          word_pulse,
   output logic                          done_pulse,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   state_t       state_q, state_d;
   logic         raw, lvl, prev, edge_det;
   logic [14:0]  div_cnt;
   logic         tick;
   logic [7:0]   dur;
   logic         emit, timeout_hit;
   symbol_t      sym_q, sym_in;
   logic         sym_valid, take, word_done;
   logic [31:0]  acc, word_next, push_word;
   logic [4:0]   nsym, push_len;
   logic         push_req, done_d;
   logic         fifo_empty, fifo_full, fifo_drop;

   assign raw = sig_in ^ invert;

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
   logic [1:0] hist;
   always_ff @(posedge clk) begin
      if (rst) hist <= '0;
      else     hist <= {hist[0], raw};
   end
   // prev doubles as the filter's held output: lvl only follows raw once it
   // has matched for the current and two previous cycles.
   assign lvl = (raw == hist[0] && raw == hist[1]) ? raw : prev;
`else
   assign lvl = raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b0;
      else     prev <= lvl;
   end
   assign edge_det = (lvl != prev);

   assign tick = ((div_cnt | (15'h7fff << prescaler)) == 15'h7fff);

   always_ff @(posedge clk) begin
      if (rst || !en || state_q == IDLE || edge_det) begin
         div_cnt <= '0;
         dur     <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         if (tick && dur != 8'hff) dur <= dur + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      emit        = 1'b0;
      timeout_hit = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ARM;
            ARM:     if (edge_det) state_d = MEASURE;
            MEASURE: begin
               if (edge_det) begin
                  emit = 1'b1;
               end else if (idle_timeout != '0 && dur == idle_timeout) begin
                  timeout_hit = 1'b1;
                  state_d     = ARM;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         sym_valid <= 1'b0;
         sym_q     <= '0;
      end else begin
         sym_valid <= emit;
         sym_q     <= classify(prev, dur, thr_low, thr_high);
      end
   end

   // Timeout symbols skip the edge register so the flush lands one cycle sooner.
   assign take      = en && (sym_valid || timeout_hit);
   assign sym_in    = timeout_hit ? classify(lvl, dur, thr_low, thr_high) : sym_q;
   assign word_next = acc | (32'(sym_in) << {nsym[3:0], 1'b0});
   assign word_done = take && (nsym == 5'(SYM_PER_WORD - 1) || timeout_hit);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         acc  <= '0;
         nsym <= '0;
      end else if (word_done) begin
         acc  <= '0;
         nsym <= '0;
      end else if (take) begin
         acc  <= word_next;
         nsym <= nsym + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         push_req  <= 1'b0;
         push_word <= '0;
         push_len  <= '0;
      end else begin
         push_req <= word_done;
         if (word_done) begin
            push_word <= word_next;
            push_len  <= nsym + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_pulse <= 1'b0;
         done_d     <= 1'b0;
         done_pulse <= 1'b0;
         last_len   <= '0;
         overflow   <= 1'b0;
      end else begin
         word_pulse <= push_req;
         done_d     <= timeout_hit;
         done_pulse <= done_d;
         if (push_req) last_len <= push_len;
         overflow <= fifo_drop || (overflow && !clr_overflow);
      end
   end

   pulse_receiver_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (push_word),
      .pop       (rd_en),
      .head      (rd_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (fifo_level),
      .drop      (fifo_drop)
   );

   assign rd_valid = !fifo_empty;

endmodule
